// File: rtl/accel_pkg.sv
// Shared definitions for the accelerator datapath: default BRAM geometry,
// read-FIFO depth and the command FSM state encoding used by the BRAM,
// reader and compute stages.
package accel_pkg;

    localparam int ACC_DWIDTH    = 16;
    localparam int ACC_AWIDTH    = 12;
    localparam int ACC_MEM_SIZE  = 3840;
    localparam int RD_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } acc_state_t;

endpackage

// File: rtl/bram_rd_fifo.sv
// Small synchronous FIFO that catches BRAM read data.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   flush        empties the FIFO (same effect as rst on pointers/count)
//   push, din    write a word
//   pop          remove the head word (ignored when empty)
//   dout, valid  head word and non-empty flag (dout forced to 0 when empty)
//   count        number of stored words, 0..DEPTH
module bram_rd_fifo #(
    parameter int DWIDTH = 16,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [DWIDTH-1:0]        din,
    input  logic                     pop,
    output logic [DWIDTH-1:0]        dout,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    assign valid   = (count != '0);
    assign pop_ok  = pop && valid;
    assign push_ok = push && (count != (PW+1)'(DEPTH));
    // Head comes straight from the storage registers; zero when empty so
    // the stream data is clean after reset.
    assign dout    = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop_ok)
                count <= count + 1'b1;
            else if (pop_ok && !push_ok)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/bram_stream_reader.sv
// Read engine for one port of the 16-bit BRAM. Walks base, base+stride, ...
// (modulo MEM_SIZE) for len words and streams them out on valid/ready.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, base, len, stride command; accepted when busy=0
//   busy, done               command in progress / 1-cycle completion pulse
//   bram_addr/ce/we/d, q     BRAM port (read only; we and d tied 0)
//   m_data/m_valid/m_last    output stream, m_ready backpressure
module bram_stream_reader
    import accel_pkg::*;
#(
    parameter int DWIDTH   = ACC_DWIDTH,
    parameter int AWIDTH   = ACC_AWIDTH,
    parameter int MEM_SIZE = ACC_MEM_SIZE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [AWIDTH-1:0] base,
    input  logic [AWIDTH-1:0] len,
    input  logic [AWIDTH-1:0] stride,
    output logic              busy,
    output logic              done,
    output logic [AWIDTH-1:0] bram_addr,
    output logic              bram_ce,
    output logic              bram_we,
    output logic [DWIDTH-1:0] bram_d,
    input  logic [DWIDTH-1:0] bram_q,
    output logic [DWIDTH-1:0] m_data,
    output logic              m_valid,
    output logic              m_last,
    input  logic              m_ready
);
    localparam int CW = $clog2(RD_FIFO_DEPTH) + 1;
    localparam logic [AWIDTH:0] MEM_SIZE_W = (AWIDTH+1)'(MEM_SIZE);

    acc_state_t        state;
    logic [AWIDTH-1:0] addr;
    logic [AWIDTH-1:0] len_r;
    logic [AWIDTH-1:0] stride_r;
    logic [AWIDTH-1:0] issued;
    logic [AWIDTH-1:0] sent;
    logic              inflight;
    logic [CW-1:0]     fifo_count;
    logic [CW-1:0]     occupancy;
    logic [AWIDTH:0]   addr_sum;
    logic [AWIDTH:0]   addr_wrap;
    logic              accept;
    logic              xfer;

    assign busy      = (state == ST_RUN);
    assign done      = (state == ST_DONE);
    assign accept    = start && !busy;
    assign xfer      = m_valid && m_ready;
    assign bram_addr = addr;
    assign bram_we   = 1'b0;
    assign bram_d    = '0;

    // Credit: a word already in the FIFO or still in the BRAM pipe each
    // hold a slot. Only registered terms, so m_ready never reaches bram_ce.
    assign occupancy = fifo_count + CW'(inflight);
    assign bram_ce   = busy && (issued < len_r) && (occupancy < CW'(RD_FIFO_DEPTH));
    assign m_last    = m_valid && (sent == len_r - AWIDTH'(1));

    assign addr_sum  = {1'b0, addr} + {1'b0, stride_r};
    assign addr_wrap = (addr_sum >= MEM_SIZE_W) ? addr_sum - MEM_SIZE_W : addr_sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            addr     <= '0;
            len_r    <= '0;
            stride_r <= '0;
            issued   <= '0;
            sent     <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= bram_ce;
            case (state)
                ST_RUN: begin
                    if (bram_ce) begin
                        addr   <= addr_wrap[AWIDTH-1:0];
                        issued <= issued + 1'b1;
                    end
                    if (xfer) sent <= sent + 1'b1;
                    if (xfer && m_last) state <= ST_DONE;
                end
                default: begin
                    // IDLE and DONE both take a new command.
                    if (accept) begin
                        addr     <= base;
                        len_r    <= len;
                        stride_r <= stride;
                        issued   <= '0;
                        sent     <= '0;
                        state    <= (len == '0) ? ST_DONE : ST_RUN;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    bram_rd_fifo #(
        .DWIDTH (DWIDTH),
        .DEPTH  (RD_FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (accept),
        .push  (inflight),
        .din   (bram_q),
        .pop   (xfer),
        .dout  (m_data),
        .valid (m_valid),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_bram_stream_reader.sv
module tb_bram_stream_reader;
    localparam int DW = 16;
    localparam int AW = 12;
    localparam int MS = 3840;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base = '0;
    logic [AW-1:0] len = '0;
    logic [AW-1:0] stride = 12'd1;
    logic          busy, done, bram_ce, bram_we, m_valid, m_last;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_d, m_data;
    logic [DW-1:0] bram_q = '0;
    logic          m_ready = 1'b0;

    bram_stream_reader dut (
        .clk(clk), .rst(rst), .start(start), .base(base), .len(len), .stride(stride),
        .busy(busy), .done(done), .bram_addr(bram_addr), .bram_ce(bram_ce),
        .bram_we(bram_we), .bram_d(bram_d), .bram_q(bram_q),
        .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready)
    );

    always #5 clk = ~clk;

    // BRAM model: one-cycle registered read
    logic [DW-1:0] mem [MS];
    always @(posedge clk) if (bram_ce) bram_q <= mem[bram_addr];

    int errs = 0;
    int checks = 0;

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    typedef struct {int data; bit last;} exp_t;
    int   exp_a[$];
    exp_t exp_d[$];
    int   ce_cnt = 0, xfer_cnt = 0, outst = 0;
    bit   mon_en = 0;
    bit   prev_stall = 0;
    int   prev_data = 0;

    // Scoreboard monitor, samples on the falling edge
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (bram_ce) begin
                ce_cnt++;
                outst++;
                if (exp_a.size() == 0) chk("ce_unexpected", bram_addr, -1);
                else chk("addr", bram_addr, exp_a.pop_front());
            end
            if (!m_valid) chk("last_without_valid", m_last, 0);
            if (m_valid && prev_stall) chk("hold_stalled", m_data, prev_data);
            if (m_valid && m_ready) begin
                xfer_cnt++;
                outst--;
                if (exp_d.size() == 0) chk("xfer_unexpected", m_data, -1);
                else begin
                    e = exp_d.pop_front();
                    chk("data", m_data, e.data);
                    chk("last", m_last, e.last);
                end
            end
            if (bram_ce) chk("occupancy_le4", outst <= 4, 1);
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end
    end

    task automatic push_exp(input int b, input int l, input int s);
        int a = b;
        for (int i = 0; i < l; i++) begin
            exp_t e;
            exp_a.push_back(a);
            e.data = (a + 100) & 16'hFFFF;
            e.last = (i == l - 1);
            exp_d.push_back(e);
            a += s;
            if (a >= MS) a -= MS;
        end
    endtask

    // Called at the drive point; returns at the drive point after the
    // edge that samples start.
    task automatic pulse_start(input int b, input int l, input int s);
        base   = AW'(b);
        len    = AW'(l);
        stride = AW'(s);
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int maxc);
        int n = 0;
        bit seen = 0;
        while (!seen && n < maxc) begin
            @(negedge clk);
            seen = done;
            n++;
        end
        chk({tag, "_done"}, seen, 1);
        @(posedge clk); #1;
        chk({tag, "_drained"}, exp_d.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, x0, n;
        bit seen;
        bit ce_h[7], v_h[7], d_h[7], b_h[7];

        for (int i = 0; i < MS; i++) mem[i] = DW'(i + 100);

        // 1: reset
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ce", bram_ce, 0);
        chk("rst_valid", m_valid, 0);
        chk("rst_last", m_last, 0);
        chk("rst_we", bram_we, 0);
        chk("rst_d", bram_d, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_ce", bram_ce, 0);
        end
        @(posedge clk); #1;
        mon_en = 1;

        // 2: basic timing, base 10 len 4
        m_ready = 1'b1;
        push_exp(10, 4, 1);
        pulse_start(10, 4, 1);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            ce_h[i] = bram_ce; v_h[i] = m_valid; d_h[i] = done; b_h[i] = busy;
        end
        for (int i = 0; i < 7; i++) begin
            chk("t2_ce_timing", ce_h[i], (i <= 3));
            chk("t2_valid_timing", v_h[i], (i >= 2 && i <= 5));
            chk("t2_done_timing", d_h[i], (i == 6));
        end
        chk("t2_busy_run", b_h[0], 1);
        chk("t2_busy_in_done", b_h[6], 0);
        @(posedge clk); #1;
        chk("t2_drained", exp_d.size(), 0);

        // 3: address wrap
        push_exp(3838, 4, 1);
        pulse_start(3838, 4, 1);
        wait_done("t3a", 40);
        push_exp(3830, 3, 5);
        pulse_start(3830, 3, 5);
        wait_done("t3b", 40);

        // 4: backpressure
        m_ready = 1'b0;
        c0 = ce_cnt; x0 = xfer_cnt;
        push_exp(200, 8, 1);
        pulse_start(200, 8, 1);
        repeat (10) @(posedge clk);
        #1;
        chk("t4_ce_stall_at4", ce_cnt - c0, 4);
        chk("t4_no_xfer", xfer_cnt - x0, 0);
        n = 0; seen = 0;
        while (!seen && n < 100) begin
            m_ready = ~m_ready;
            @(negedge clk);
            seen = done;
            @(posedge clk); #1;
            n++;
        end
        chk("t4_done", seen, 1);
        m_ready = 1'b1;
        chk("t4_ce_total", ce_cnt - c0, 8);
        chk("t4_xfer_total", xfer_cnt - x0, 8);
        chk("t4_drained", exp_d.size(), 0);

        // 5: len=0, then start while busy
        c0 = ce_cnt; x0 = xfer_cnt;
        pulse_start(5, 0, 1);
        @(negedge clk);
        chk("t5_len0_done", done, 1);
        chk("t5_len0_busy", busy, 0);
        chk("t5_len0_ce", bram_ce, 0);
        chk("t5_len0_valid", m_valid, 0);
        @(negedge clk);
        chk("t5_len0_pulse1", done, 0);
        chk("t5_len0_noce", ce_cnt - c0, 0);
        @(posedge clk); #1;
        push_exp(20, 4, 1);
        pulse_start(20, 4, 1);
        @(posedge clk); #1;
        chk("t5_busy_before_ignored", busy, 1);
        pulse_start(500, 2, 1);
        wait_done("t5", 40);
        chk("t5_xfer_count", xfer_cnt - x0, 4);

        // 6: reset mid-command
        x0 = xfer_cnt;
        push_exp(50, 6, 1);
        pulse_start(50, 6, 1);
        n = 0;
        while ((xfer_cnt - x0) < 2 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("t6_reached_2", (xfer_cnt - x0) >= 2, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_a.delete(); exp_d.delete();
        outst = 0; prev_stall = 0;
        @(negedge clk);
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_ce", bram_ce, 0);
        chk("t6_valid", m_valid, 0);
        chk("t6_last", m_last, 0);
        chk("t6_addr", bram_addr, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t6_no_done", done, 0);
        end
        @(posedge clk); #1;
        x0 = xfer_cnt;
        push_exp(0, 2, 1);
        pulse_start(0, 2, 1);
        wait_done("t6_restart", 40);
        chk("t6_restart_xfer", xfer_cnt - x0, 2);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
